// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared types and constants for the mux_pipe_sel slice.
//   occ_state_t : occupancy of the 2-entry output stage (EMPTY/ONE/TWO)
//   OOR_CNT_W   : width of the saturating out-of-range beat counter
package mux_pipe_pkg;

  localparam int unsigned OOR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid: 2-entry output stage (OUT register + skid register) with a
// registered in_ready, so upstream never sees a combinational path from
// out_ready. OUT is always presented first; skid refills OUT when it drains.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_data/in_valid    upstream payload and valid
//   in_ready            registered, 1 iff skid is empty
//   out_data/out_valid  registered payload and valid
//   out_ready           downstream ready
module mux_pipe_skid
  import mux_pipe_pkg::*;
#(
  parameter int unsigned PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  occ_state_t    r_state;
  occ_state_t    w_state_nxt;
  logic [PW-1:0] r_out;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_out_nxt;
  logic [PW-1:0] w_skid_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_in_xfer;
  logic          w_out_xfer;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  // State and storage registers; ready/valid are derived from the next state
  // so they are registered yet exact on the cycle after each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out       <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != TWO);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  // Occupancy next-state and data movement.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ONE;
          w_out_nxt   = in_data;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_out_nxt = in_data;
        end else if (w_in_xfer) begin
          w_state_nxt = TWO;
          w_skid_nxt  = in_data;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is 0 here, so only the drain path exists.
        if (w_out_xfer) begin
          w_state_nxt = ONE;
          w_out_nxt   = r_skid;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

endmodule

// File: rtl/mux_pipe_sel.sv
// mux_pipe_sel: N-way, W-bit channel select feeding a 2-entry registered
// output stage with valid/ready handshakes on both sides. An out-of-range
// select (s >= N) yields all-zeros.
// Optional feature (macro MUX_PIPE_OOR_EN): per-beat out-of-range flag oor
// carried alongside the data, and saturating 8-bit counter oor_cnt of
// out-of-range beats delivered downstream.
// Ports:
//   clk, rst             clock, async active-high reset
//   i [N*W]              packed channel data, channel k = i[k*W +: W]
//   s [SW]               channel select, sampled with i
//   in_valid / in_ready  upstream handshake (in_ready registered)
//   o [W]                selected data, registered
//   out_valid/out_ready  downstream handshake
//   oor, oor_cnt         (MUX_PIPE_OOR_EN only) range flag and counter
module mux_pipe_sel
  import mux_pipe_pkg::*;
#(
  parameter int N  = 9,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       i,
  input  logic [SW-1:0]        s,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         o,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_PIPE_OOR_EN
  ,
  output logic                 oor,
  output logic [OOR_CNT_W-1:0] oor_cnt
`endif
);

  logic [W-1:0] w_sel;
`ifdef MUX_PIPE_OOR_EN
  logic         w_oor;
`endif

  // Select decode: only matching in-range channels drive, so s >= N gives zeros.
  always_comb begin
    w_sel = '0;
`ifdef MUX_PIPE_OOR_EN
    w_oor = 1'b1;
`endif
    for (int k = 0; k < N; k++) begin
      if (s == SW'(k)) begin
        w_sel = i[k*W +: W];
`ifdef MUX_PIPE_OOR_EN
        w_oor = 1'b0;
`endif
      end
    end
  end

`ifdef MUX_PIPE_OOR_EN
  localparam int unsigned PW = W + 1;

  logic [PW-1:0]        w_out_payload;
  logic [OOR_CNT_W-1:0] r_oor_cnt;

  // Flag rides in the MSB so it follows its beat through both entries.
  mux_pipe_skid #(.PW(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({w_oor, w_sel}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (w_out_payload),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign o   = w_out_payload[W-1:0];
  assign oor = w_out_payload[W];

  // Saturating count of out-of-range beats delivered downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oor_cnt <= '0;
    end else if (out_valid && out_ready && oor && (r_oor_cnt != '1)) begin
      r_oor_cnt <= r_oor_cnt + OOR_CNT_W'(1);
    end
  end

  assign oor_cnt = r_oor_cnt;
`else
  mux_pipe_skid #(.PW(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (w_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );
`endif

endmodule

// File: tb/tb_mux_pipe_sel.sv
// tb_mux_pipe_sel: scoreboard bench for mux_pipe_sel (N=9, W=8). Expected
// beats are queued at each input transfer from a plain array-index model and
// popped by an independent monitor at each output transfer.
module tb_mux_pipe_sel;

  localparam int N  = 9;
  localparam int W  = 8;
  localparam int SW = 4;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] i;
  logic [SW-1:0]  s;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   o;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_PIPE_OOR_EN
  logic           oor;
  logic [7:0]     oor_cnt;
`endif

  mux_pipe_sel #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_PIPE_OOR_EN
    ,
    .oor       (oor),
    .oor_cnt   (oor_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  logic [8:0] sbq[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_o     = '0;
  logic       prev_oor   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: channel s if in range, else zero with the range flag set.
  function automatic logic [8:0] model(input logic [N*W-1:0] iv, input logic [SW-1:0] sv);
    int idx;
    idx = int'(sv);
    if (idx < N) return {1'b0, iv[idx*W +: W]};
    return {1'b1, 8'h00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chans_ramp();
    for (int k = 0; k < N; k++) i[k*W +: W] = 8'(k + 16);
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && (sbq.size() != 0 || out_valid); c++) tick();
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  // Input side of the scoreboard: record the expected beat at each transfer.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sbq.push_back(model(i, s));
      n_in++;
    end
  end

  // Output side: compare every delivered beat and stall stability.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_o", 32'(o), 32'(prev_o));
`ifdef MUX_PIPE_OOR_EN
        chk("stall_oor", 32'(oor), 32'(prev_oor));
`endif
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("out_data", 32'(o), 32'(e[7:0]));
`ifdef MUX_PIPE_OOR_EN
          chk("out_oor", 32'(oor), 32'(e[8]));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = o;
`ifdef MUX_PIPE_OOR_EN
      prev_oor   = oor;
`endif
    end
  end

  initial begin
    rst       = 1'b1;
    i         = '0;
    s         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_o", 32'(o), 32'd0);
`ifdef MUX_PIPE_OOR_EN
    chk("rst_oor", 32'(oor), 32'd0);
    chk("rst_oor_cnt", 32'(oor_cnt), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Single beat, one-cycle latency.
    set_chans_ramp();
    s         = 4'd4;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk("lat_pre_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_o", 32'(o), 32'h14);
    drain("lat_drain");

    // Back-to-back sweep of every channel at full throughput.
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      s = SW'(k);
      chk("sweep_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("sweep_valid", 32'(out_valid), 32'd1);
      chk("sweep_o", 32'(o), 32'(k + 16));
    end
    drain("sweep_drain");

    // Fill both entries with downstream stalled, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s = 4'd1;
    tick();
    chk("fill1_in_ready", 32'(in_ready), 32'd1);
    s = 4'd2;
    tick();
    chk("fill2_in_ready", 32'(in_ready), 32'd0);
    s = 4'd3;
    tick();
    chk("fill3_in_ready", 32'(in_ready), 32'd0);
    chk("fill3_o", 32'(o), 32'h11);
    chk("fill3_held", 32'(sbq.size()), 32'd2);
    drain("fill_drain");

    // Out-of-range select: zeros, flagged, counter saturates.
    s         = 4'd12;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("oor_o", 32'(o), 32'd0);
`ifdef MUX_PIPE_OOR_EN
    chk("oor_flag", 32'(oor), 32'd1);
`endif
    for (int k = 1; k < 300; k++) tick();
    drain("oor_drain");
`ifdef MUX_PIPE_OOR_EN
    chk("oor_cnt_sat", 32'(oor_cnt), 32'd255);
`endif

    // Reset while both entries are held: both beats are discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s = 4'd5;
    tick();
    s = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("two_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_o", 32'(o), 32'd0);
`ifdef MUX_PIPE_OOR_EN
    chk("mid_rst_oor_cnt", 32'(oor_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    s = 4'd7;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_o", 32'(o), 32'h17);
    drain("post_rst_drain");

    // Random data, selects and stalls on both sides.
    n_in = 0;
    for (int c = 0; c < 40000 && n_in < 10000; c++) begin
      for (int k = 0; k < N; k++) i[k*W +: W] = 8'($urandom);
      s         = SW'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    chk("rand_beats", 32'(n_in >= 10000), 32'd1);
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_pipe_sel.md
MUX_PIPE_SEL -- requirements
Module: mux_pipe_sel

Interface
REQ-001 The block SHALL have parameter N, default 9, number of input channels (N >= 2).
REQ-002 The block SHALL have parameter W, default 1, data width per channel (W >= 1).
REQ-003 The block SHALL have parameter SW, default $clog2(N), select width.
REQ-004 The block SHALL have port clk  input  1  the single clock, rising-edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port i  input  N*W  packed channel data; channel k is i[k*W +: W].
REQ-007 The block SHALL have port s  input  SW  channel select, sampled with i.
REQ-008 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), forming the upstream handshake.
REQ-009 The block SHALL have port o  output  W  selected data, registered.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream handshake.
REQ-011 Under MUX_PIPE_OOR_EN, the block SHALL have ports oor (output, 1, per-beat out-of-range flag) and oor_cnt (output, 8, saturating count of out-of-range beats).

Function
- REQ-012 An input beat SHALL transfer on a rising edge where in_valid and in_ready are both 1.
- REQ-013 An output beat SHALL transfer on a rising edge where out_valid and out_ready are both 1.
- REQ-014 The selected value SHALL be i[s*W +: W] when s < N.
- REQ-015 When s >= N, the selected value SHALL be all-zeros; no X is ever driven.
- REQ-016 The latency from input transfer to out_valid SHALL be exactly 1 cycle when the output is empty or draining.
- REQ-017 Storage SHALL be 2 entries: an output register and a skid register. The output register (OUT) is always consumed first.
- REQ-018 in_ready SHALL be registered: 1 iff the skid register is empty. It SHALL never depend combinationally on out_ready.
- REQ-019 The occupancy states SHALL be EMPTY (0 entries), ONE (OUT full) and TWO (OUT and skid full).
- REQ-020 EMPTY + input transfer SHALL go to ONE.
- REQ-021 ONE + input transfer without output transfer SHALL go to TWO; the skid register captures the beat.
- REQ-022 ONE + output transfer without input transfer SHALL go to EMPTY.
- REQ-023 ONE + simultaneous input and output transfer SHALL stay in ONE, with OUT loaded with the new beat.
- REQ-024 TWO + output transfer SHALL go to ONE, with skid contents moved to OUT. No input transfer is possible in TWO, since in_ready is 0.
- REQ-025 With out_ready held 1, throughput SHALL be one beat per cycle.
- REQ-026 o and oor SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-027 o SHALL retain its last value when out_valid=0; it is don't-care for checking.
- REQ-028 oor SHALL travel with its beat through both storage entries.
- REQ-029 oor_cnt SHALL increment by 1 on each output transfer whose oor=1, and SHALL saturate at 255.

Reset
- REQ-030 Asserting rst at any time SHALL immediately clear out_valid to 0, in_ready to 1, oor to 0, oor_cnt to 0 and o to 0, and SHALL set the state to EMPTY.
- REQ-031 Beats held at the time of reset SHALL be discarded without being presented.
- REQ-032 After rst deasserts, the first rising edge SHALL accept input normally.

Configuration
- REQ-033 With macro MUX_PIPE_OOR_EN defined, the block SHALL have ports oor and oor_cnt, and the per-beat flag storage and counter SHALL be present.
- REQ-034 Without MUX_PIPE_OOR_EN, those ports and that logic SHALL be absent; out-of-range selection SHALL still produce zeros.

Structure
- REQ-035 Package mux_pipe_pkg SHALL hold the occupancy state enum (EMPTY/ONE/TWO) and the constant OOR_CNT_W = 8.
- REQ-036 The 2-entry skid storage SHALL be the sub-module mux_pipe_skid, parametrised by payload width (W, or W+1 with MUX_PIPE_OOR_EN).
- REQ-037 The top level SHALL contain only the select decode and the oor counter.

Verification
- REQ-038 N=9, W=8, channel k = k+0x10, s=4, out_ready=1: o=0x14 with out_valid one cycle after the transfer.
- REQ-039 s swept 0..8 back-to-back with out_ready=1: nine consecutive beats with o=0x10..0x18, in_ready never drops.
- REQ-040 out_ready=0, three input attempts: two accepted, in_ready=0 after the second; then out_ready=1: beats emerge in order with no loss or duplication.
- REQ-041 s=12 (out of range), MUX_PIPE_OOR_EN defined: o=0x00 and oor=1 on that beat; after 300 such beats oor_cnt=255.
- REQ-042 rst pulsed while in TWO: out_valid=0 and in_ready=1 immediately; neither held beat is ever presented.
- REQ-043 Random valid/ready stalls over 10k beats: output sequence equals the scoreboard model, and o stays stable during every stall.
